// File: rtl/data_memory_stage_pkg.sv
// Shared MIPS datapath definitions used by the data-memory stage.
// Contents: MemSize encodings and the default data-memory depth.
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int DEFAULT_DMEM_DEPTH_LOG2 = 6;

endpackage

// File: rtl/data_memory_stage_if.sv
// Memory-stage request/response bundle between the datapath and data memory.
// master: drives MemWrite/MemRead/MemSize/MemUnsigned/Addr/WriteData/err_clr;
// slave: drives ReadData/misaligned/err_sticky/err_addr.
interface data_memory_stage_if;

    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        err_clr;
    logic [31:0] ReadData;
    logic        misaligned;
    logic        err_sticky;
    logic [31:0] err_addr;

    modport master (
        output MemWrite, MemRead, MemSize, MemUnsigned,
        output Addr, WriteData, err_clr,
        input  ReadData, misaligned, err_sticky, err_addr
    );

    modport slave (
        input  MemWrite, MemRead, MemSize, MemUnsigned,
        input  Addr, WriteData, err_clr,
        output ReadData, misaligned, err_sticky, err_addr
    );

endinterface

// File: rtl/data_memory_stage_load_align_ext.sv
// Load aligner: picks the addressed byte/halfword out of a raw memory word
// and sign- or zero-extends it. Ports: i_word, i_lane, i_size, i_unsigned -> o_data.
module load_align_ext
    import mips_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_lane +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = '0;
        unique case (i_size)
            SIZE_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            SIZE_WORD: o_data = i_word;
            default:   o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_stage.sv
// Data-memory stage: little-endian byte/half/word RAM with combinational
// loads, lane-masked stores, misalignment detection and a sticky error record.
// Ports: clk, rst (async, active-high), bus (data_memory_stage_if.slave).
module data_memory_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DMEM_DEPTH_LOG2
)(
    input  logic                 clk,
    input  logic                 rst,
    data_memory_stage_if.slave   bus
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [WORDS];
    logic                  r_err_sticky;
    logic [31:0]           r_err_addr;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_access;
    logic                  w_mis;
    logic                  w_we;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_raw;
    logic [31:0]           w_ext;

    // Upper address bits are dropped here, so addresses wrap silently.
    assign w_idx    = bus.Addr[DEPTH_LOG2+1:2];
    assign w_access = bus.MemRead | bus.MemWrite;

    // Illegal size is flagged unconditionally so it never acts as a word.
    assign w_mis = w_access &
                   ((bus.MemSize == SIZE_ILLEGAL) |
                    ((bus.MemSize == SIZE_HALF) & bus.Addr[0]) |
                    ((bus.MemSize == SIZE_WORD) & (bus.Addr[1:0] != 2'b00)));

    assign w_we = bus.MemWrite & ~w_mis;

    // Store data is replicated across lanes; w_be picks which lanes land.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.WriteData;
        unique case (bus.MemSize)
            SIZE_BYTE: begin
                w_be[bus.Addr[1:0]] = 1'b1;
                w_wdata = {4{bus.WriteData[7:0]}};
            end
            SIZE_HALF: begin
                w_be    = bus.Addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.WriteData[15:0]}};
            end
            SIZE_WORD: w_be = 4'b1111;
            default:   w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // A new error beats a same-cycle clear; only the first address is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= '0;
        end else if (w_mis) begin
            if (!r_err_sticky) begin
                r_err_sticky <= 1'b1;
                r_err_addr   <= bus.Addr;
            end
        end else if (bus.err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= '0;
        end
    end

    assign w_raw = r_mem[w_idx];

    load_align_ext u_load_align_ext (
        .i_word     (w_raw),
        .i_lane     (bus.Addr[1:0]),
        .i_size     (bus.MemSize),
        .i_unsigned (bus.MemUnsigned),
        .o_data     (w_ext)
    );

    assign bus.ReadData   = (bus.MemRead & ~w_mis) ? w_ext : 32'h0;
    assign bus.misaligned = w_mis;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_addr   = r_err_addr;

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: expected values are queued as each
// access is driven and popped when the DUT output is sampled.
module tb_data_memory_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_memory_stage_if bus ();

    data_memory_stage #(.DEPTH_LOG2(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic cmp(input logic [31:0] obs);
        sb_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h, no expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h",
                       e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic clr);
        bus.MemRead     = rd;
        bus.MemWrite    = wr;
        bus.MemSize     = size;
        bus.MemUnsigned = uns;
        bus.Addr        = addr;
        bus.WriteData   = wd;
        bus.err_clr     = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd);
        drive(1'b0, 1'b1, size, 1'b0, addr, wd, 1'b0);
        tick();
        idle();
    endtask

    task automatic load(input string tag, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] exp);
        drive(1'b1, 1'b0, size, uns, addr, 32'h0, 1'b0);
        push(tag, exp);
        #1;
        cmp(bus.ReadData);
        tick();
        idle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        push("rst_rd", 32'h0);
        push("rst_mis", 32'h0);
        push("rst_sticky", 32'h0);
        #1;
        cmp(bus.ReadData);
        cmp(32'(bus.misaligned));
        cmp(32'(bus.err_sticky));
        tick();
        idle();

        // word store and readbacks
        store(2'b10, 32'h10, 32'hDEADBEEF);
        load("lw10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        load("lbu11", 2'b00, 1'b1, 32'h11, 32'h000000BE);
        load("lb11", 2'b00, 1'b0, 32'h11, 32'hFFFFFFBE);
        load("lb13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE);
        load("lhu12", 2'b01, 1'b1, 32'h12, 32'h0000DEAD);
        load("lh10", 2'b01, 1'b0, 32'h10, 32'hFFFFBEEF);
        load("lhu10", 2'b01, 1'b1, 32'h10, 32'h0000BEEF);

        // partial stores only touch addressed lanes
        store(2'b00, 32'h12, 32'hAAAAAA55);
        load("sb_lw", 2'b10, 1'b0, 32'h10, 32'hDE55BEEF);
        store(2'b01, 32'h10, 32'hFFFF1234);
        load("sh_lw", 2'b10, 1'b0, 32'h10, 32'hDE551234);

        // misaligned store
        store(2'b10, 32'h14, 32'h01020304);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h16, 32'hFFFFFFFF, 1'b0);
        push("mis_st", 32'h1);
        #1;
        cmp(32'(bus.misaligned));
        tick();
        idle();
        push("st_sticky", 32'h1);
        push("st_eaddr", 32'h16);
        cmp(32'(bus.err_sticky));
        cmp(bus.err_addr);
        load("mis_nowr", 2'b10, 1'b0, 32'h14, 32'h01020304);

        // second error keeps first address
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0);
        push("lh21_mis", 32'h1);
        push("lh21_rd", 32'h0);
        #1;
        cmp(32'(bus.misaligned));
        cmp(bus.ReadData);
        tick();
        idle();
        push("keep_eaddr", 32'h16);
        cmp(bus.err_addr);

        // clear with no access
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        idle();
        push("clr_sticky", 32'h0);
        push("clr_eaddr", 32'h0);
        cmp(32'(bus.err_sticky));
        cmp(bus.err_addr);

        // error beats same-cycle clear
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 1'b1);
        push("lw21_rd", 32'h0);
        #1;
        cmp(bus.ReadData);
        tick();
        idle();
        push("win_sticky", 32'h1);
        push("win_eaddr", 32'h21);
        cmp(32'(bus.err_sticky));
        cmp(bus.err_addr);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        idle();

        // illegal size at aligned address
        drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        push("sz11_mis", 32'h1);
        push("sz11_rd", 32'h0);
        #1;
        cmp(32'(bus.misaligned));
        cmp(bus.ReadData);
        tick();
        idle();

        // alias
        store(2'b10, 32'h104, 32'hA5A5A5A5);
        load("alias", 2'b10, 1'b0, 32'h004, 32'hA5A5A5A5);

        // read during write
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h77, 1'b0);
        push("rdw_old", 32'h0);
        #1;
        cmp(bus.ReadData);
        tick();
        bus.MemWrite = 1'b0;
        push("rdw_new", 32'h77);
        #1;
        cmp(bus.ReadData);
        idle();

        // async reset mid-cycle; sticky is set first
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 1'b0);
        push("pre_rst", 32'hA5A5A5A5);
        push("pre_sticky", 32'h1);
        #1;
        cmp(bus.ReadData);
        cmp(32'(bus.err_sticky));
        #1;
        rst = 1'b1;
        #1;
        push("arst_rd", 32'h0);
        push("arst_sticky", 32'h0);
        cmp(bus.ReadData);
        cmp(32'(bus.err_sticky));

        // store during reset is discarded
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'hC, 32'h12345678, 1'b0);
        tick();
        idle();
        #1;
        rst = 1'b0;
        tick();
        load("rst_st_drop", 2'b10, 1'b0, 32'hC, 32'h0);
        load("rst_alias", 2'b10, 1'b0, 32'h004, 32'h0);
        store(2'b10, 32'h0, 32'h11223344);
        load("resume", 2'b10, 1'b0, 32'h0, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
Memory-access stage that sits directly downstream of the ALU in the single-cycle datapath. The ALU result is the byte address; RD2 of the register file is the store data. The block provides:
- byte/halfword/word loads and stores, with sign or zero extension on loads;
- misalignment detection;
- a sticky error record.
ReadData feeds the write-back mux (MemtoReg).

Parameters:
DEPTH_LOG2, 6, log2 of number of 32-bit words (default 64 words = 256 bytes)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
MemWrite  input  1  store request this cycle
MemRead  input  1  load request this cycle
MemSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal
MemUnsigned  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend (lb/lh)
Addr  input  32  byte address, driven from the ALU result
WriteData  input  32  store data; byte/half taken from low bits
err_clr  input  1  clears the sticky error record
ReadData  output  32  load result (combinational)
misaligned  output  1  current access is illegal (combinational)
err_sticky  output  1  an illegal access has occurred since reset/clear
err_addr  output  32  Addr of the first illegal access since reset/clear

Behaviour:
- Storage: 2**DEPTH_LOG2 words, little-endian. Byte lane k = bits 8k+7:8k.
- Word index = Addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias (wrap-around) with no error.
- Byte lane = Addr[1:0].
- misaligned = (MemRead|MemWrite) & (MemSize==11 | (MemSize==01 & Addr[0]) | (MemSize==10 & Addr[1:0]!=0)). Purely combinational.
- Loads: zero latency; ReadData is combinational from the array, as the single-cycle datapath requires.
  - Byte: lane selected by Addr[1:0].
  - Half: lanes {Addr[1],0} and {Addr[1],1}.
  - Word: full word.
  - Sign-extension from bit 7 / bit 15 unless MemUnsigned=1.
  - ReadData = 0 when MemRead=0 or misaligned=1.
- Stores: committed at the rising clk edge when MemWrite=1 & misaligned=0. Only the addressed lanes are written; the other lanes are unchanged.
  - Byte: WriteData[7:0] to lane Addr[1:0].
  - Half: WriteData[15:0] to lanes {Addr[1],1:0}.
  - Word: all 32 bits.
  - A misaligned store writes nothing.
- MemRead & MemWrite in the same cycle: ReadData shows the pre-store contents during that cycle. The new data is visible from the next cycle.
- Error record, updated at each clk edge:
  - If misaligned=1 & err_sticky=0: err_sticky<=1 and err_addr<=Addr.
  - If misaligned=1 & err_sticky=1: err_addr holds (first error kept).
  - Else if err_clr=1: err_sticky<=0 and err_addr<=0.
  - err_clr and a new illegal access in the same cycle: the new error wins (set and capture Addr).
- Reset (async, immediate):
  - All array words = 0; err_sticky = 0; err_addr = 0.
  - ReadData = 0 and misaligned follows its inputs combinationally.
  - A store whose edge coincides with asserted rst is discarded.
  - Deasserting rst mid-sequence resumes cleanly from the cleared state.
- No X propagation: MemSize=11 is always treated as illegal, never as a silent word access.

Decomposition:
- Shared package (mips_pkg): MemSize encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_ILLEGAL=2'b11; DEFAULT_DMEM_DEPTH_LOG2=6.
- One natural sub-module: load_align_ext. Combinational; takes the raw word, Addr[1:0], MemSize and MemUnsigned, and produces the extended ReadData.
- Store lane-enable generation and the error record stay in the top module.

Test Plan:
- Reset then word load: rst pulse, MemRead=1, Addr=0x40, MemSize=10 -> ReadData=0x00000000, misaligned=0, err_sticky=0.
- Word store/readback: sw 0xDEADBEEF at 0x10, then lw 0x10 -> 0xDEADBEEF.
  - lbu 0x11 -> 0x000000BE; lb 0x13 -> 0xFFFFFFDE.
  - lhu 0x12 -> 0x0000DEAD; lh 0x10 -> 0xFFFFBEEF.
- Partial stores: after the above, sb 0x55 at 0x12 -> lw 0x10 = 0xDE55BEEF. Then sh 0x1234 at 0x10 -> lw 0x10 = 0xDE551234.
- Misaligned store: sw 0xFFFFFFFF at Addr=0x16.
  - misaligned=1 that cycle.
  - Memory unchanged: lw 0x14 returns its prior value.
  - Next cycle err_sticky=1, err_addr=0x16.
  - Later lh at 0x21 keeps err_addr=0x16.
  - err_clr=1 with no access -> err_sticky=0, err_addr=0.
- Same-cycle error and clear: lw at 0x21 with err_clr=1 and MemRead=1 -> err_sticky=1 and err_addr=0x21 after the edge. ReadData=0 during the illegal cycle.
- Alias, read-during-write and reset: sw 0xA5A5A5A5 at 0x104 (DEPTH_LOG2=6) -> lw 0x004 = 0xA5A5A5A5.
  - MemRead & MemWrite at 0x8 with old 0x0 and new 0x77 -> ReadData=0 that cycle, 0x77 next cycle.
  - Assert rst asynchronously mid-cycle -> lw 0x004 = 0 immediately and err_sticky=0.
